rgb_to_ycbcr: RTL and testbench
===============================

// Module: rgb_to_ycbcr
// PURPOSE
//  Inverse of the YCbCr->RGB path: accepts one byte per valid cycle, serialised R,G,B per pixel,
//  and emits one full-range BT.601 Y/Cb/Cr triple per pixel, all three components in parallel.
//  Sits at the front of the processing chain (camera/DMA byte stream -> YCbCr planes).
//  Multiply-accumulate per incoming byte, then a round/clamp stage.
// PARAMETERS
//  ACC_W   18  signed accumulator width (covers -32640..65536 plus sign)
//  FRAC    8   fixed-point fraction bits of coefficients (result = acc >>> FRAC)
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  asynchronous, active-high reset
//  valid_i     in   1  rgb_data_i is valid this cycle; no backpressure, always accepted
//  sof_i       in   1  qualified by valid_i: this byte is the R of a new frame's first pixel
//  rgb_data_i  in   8  unsigned sample; channel given by internal phase (R->G->B)
//  valid_o     out  1  one-cycle pulse; y/cb/cr outputs valid
//  y_data_o    out  8  luma
//  cb_data_o   out  8  blue-difference chroma, offset 128
//  cr_data_o   out  8  red-difference chroma, offset 128
//  phase_o     out  2  channel expected next: 0=R, 1=G, 2=B (3 never occurs)
//  err_o       out  1  one-cycle pulse: sof_i arrived with phase != R (partial pixel dropped)
// BEHAVIOUR
//  Reset: phase=R, accumulators=0, sum_vld=0, valid_o=0, y/cb/cr=0, err_o=0.
//  Coefficients: Y = 77R+150G+29B; Cb = -43R-85G+128B; Cr = 128R-107G-21B.
//  Bias: Y_BIAS=128 (rounding), C_BIAS=32896 (128<<8 + 128), both loaded with the R byte.
//  Phase FSM (advances only on valid_i): R->G->B->R. valid_i low holds phase and accumulators.
//  R byte: acc_y<=Y_BIAS+77R; acc_cb<=C_BIAS-43R; acc_cr<=C_BIAS+128R (overwrites, no clear needed).
//  G byte: acc_x <= acc_x + coef_G*G.
//  B byte (edge N): sum_x <= acc_x + coef_B*B, sum_vld<=1; accumulators free for next pixel.
//  Edge N+1: each out = sat(sum_x >>> FRAC) to 0..255 (neg ->0, >255 ->255); valid_o<=sum_vld.
//  Latency: valid_o high in the cycle after edge N+1 (2 cycles from B byte); throughput 1 pixel/3 valid bytes.
//  Back-to-back pixels with valid_i held high: valid_o pulses every 3rd cycle; no overlap hazard.
//  Outputs hold last value while valid_o low.
//  sof_i & valid_i with phase==R: normal R byte. With phase!=R: partial pixel discarded (no valid_o
//  for it), byte treated as R, phase->G, err_o pulses next cycle.
//  sof_i without valid_i: ignored.
//  Reset mid-pixel: partial pixel lost; an in-flight sum_vld is cleared, so no valid_o after reset.
//  Arithmetic: products 8x8 unsigned by signed constants, sign-extended to ACC_W; no overflow in range.
// STRUCTURE
//  Package ycbcr_pkg: coefficient localparams (Y_R/Y_G/Y_B, CB_R/CB_G/CB_B, CR_R/CR_G/CR_B),
//  Y_BIAS, C_BIAS, phase encoding PH_R/PH_G/PH_B, shared with ycbcr_to_rgb.
//  One sub-module: rgb_to_ycbcr_mac (one instance per component: coef select by phase,
//  accumulate, final-sum register). Phase FSM, error logic and clamp stage live in the top.
// TESTING
//  1 White 255,255,255 -> Y=255, Cb=128, Cr=128; valid_o exactly 2 cycles after B byte.
//  2 Black 0,0,0 -> Y=0, Cb=128, Cr=128. Red 255,0,0 -> Y=77, Cb=85, Cr=255 (clamped).
//  3 Blue 0,0,255 -> Y=29, Cb=255 (clamped from 256), Cr=107.
//  4 Red with valid_i low 2 cycles between R/G and G/B -> same 77/85/255; phase_o holds during gaps.
//  5 R,G then sof_i with white pixel -> err_o one pulse, no valid_o for partial, white output 255/128/128.
//  6 rst pulsed after R,G of a pixel and 1 cycle after a B byte -> no valid_o; next pixel correct.
//  Plus continuous random stream vs. integer reference model; check valid_o every 3rd cycle.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared constants for the BT.601 full-range RGB <-> YCbCr paths.
// Coefficients are signed fixed point with 8 fraction bits. Y_BIAS is the
// rounding half-LSB. C_BIAS adds the chroma offset (128<<8) plus the
// rounding half-LSB. The phase encoding names the channel expected next.
package ycbcr_pkg;

  localparam int Y_R  = 77;
  localparam int Y_G  = 150;
  localparam int Y_B  = 29;

  localparam int CB_R = -43;
  localparam int CB_G = -85;
  localparam int CB_B = 128;

  localparam int CR_R = 128;
  localparam int CR_G = -107;
  localparam int CR_B = -21;

  localparam int Y_BIAS = 128;
  localparam int C_BIAS = 32896;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

endpackage

// File: rtl/rgb_to_ycbcr_if.sv
// Byte-stream in / YCbCr triple out bundle for rgb_to_ycbcr.
//   valid_i, sof_i, rgb_data_i : serialised R,G,B byte stream (no backpressure)
//   valid_o, y/cb/cr_data_o    : one-cycle pulse with the converted pixel
//   phase_o                    : channel expected next (0=R, 1=G, 2=B)
//   err_o                      : pulse when sof_i cut a partial pixel short
// slave is the converter side, master is the producer/consumer side.
interface rgb_to_ycbcr_if;
  logic       valid_i;
  logic       sof_i;
  logic [7:0] rgb_data_i;
  logic       valid_o;
  logic [7:0] y_data_o;
  logic [7:0] cb_data_o;
  logic [7:0] cr_data_o;
  logic [1:0] phase_o;
  logic       err_o;

  modport slave (
    input  valid_i, sof_i, rgb_data_i,
    output valid_o, y_data_o, cb_data_o, cr_data_o, phase_o, err_o
  );

  modport master (
    output valid_i, sof_i, rgb_data_i,
    input  valid_o, y_data_o, cb_data_o, cr_data_o, phase_o, err_o
  );
endinterface

// File: rtl/rgb_to_ycbcr_mac.sv
// One colour component's multiply-accumulate.
//   clk, rst  : clock, async active-high reset
//   valid_i   : byte accepted this cycle
//   phase_i   : channel of the current byte (already forced to R on sof)
//   data_i    : unsigned 8-bit sample
//   sum_o     : completed pixel sum, updated on the B byte
// The R byte overwrites the accumulator with bias + product, so no separate
// clear is needed between pixels. The B byte lands in sum_q instead of the
// accumulator, leaving the accumulator free for the next pixel's R byte.
module rgb_to_ycbcr_mac
  import ycbcr_pkg::*;
#(
  parameter int ACC_W  = 18,
  parameter int COEF_R = 0,
  parameter int COEF_G = 0,
  parameter int COEF_B = 0,
  parameter int BIAS   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  phase_e                  phase_i,
  input  logic [7:0]              data_i,
  output logic signed [ACC_W-1:0] sum_o
);

  localparam logic signed [ACC_W-1:0] BIAS_S = ACC_W'(BIAS);

  logic signed [ACC_W-1:0] coef;
  logic signed [ACC_W-1:0] data_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;

  always_comb begin
    coef = ACC_W'(COEF_R);
    case (phase_i)
      PH_G:    coef = ACC_W'(COEF_G);
      PH_B:    coef = ACC_W'(COEF_B);
      default: coef = ACC_W'(COEF_R);
    endcase
  end

  assign data_ext = ACC_W'(data_i);
  assign prod     = coef * data_ext;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (valid_i) begin
      case (phase_i)
        PH_G:    acc_d = acc_q + prod;
        PH_B:    sum_d = acc_q + prod;
        default: acc_d = BIAS_S + prod;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// Serial R,G,B byte stream to parallel full-range BT.601 Y/Cb/Cr.
//   clk, rst : clock, async active-high reset
//   bus      : rgb_to_ycbcr_if.slave (byte stream in, pixel out, phase, err)
// Pipeline: the B byte closes the per-component sums (edge N). The sums are
// rounded, shifted and clamped into the output registers on edge N+1.
//
// Phase FSM
//   state | meaning
//   PH_R  | next byte is R: reload accumulators with bias + R term
//   PH_G  | next byte is G: accumulate G term
//   PH_B  | next byte is B: final sum, flag pixel complete
// sof_i with valid_i forces the byte to be treated as R from any state.
module rgb_to_ycbcr
  import ycbcr_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int FRAC  = 8
) (
  input  logic            clk,
  input  logic            rst,
  rgb_to_ycbcr_if.slave   bus
);

  phase_e     phase_q, phase_d;
  phase_e     phase_eff;
  logic       sum_vld_q, sum_vld_d;
  logic       valid_q, valid_d;
  logic [7:0] y_q, y_d;
  logic [7:0] cb_q, cb_d;
  logic [7:0] cr_q, cr_d;
  logic       err_q, err_d;

  logic signed [ACC_W-1:0] sum_y, sum_cb, sum_cr;

  // Drop the fraction bits, then clamp to 0..255.
  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> FRAC;
    if (s[ACC_W-1])
      return 8'd0;
    else if (|s[ACC_W-2:8])
      return 8'hFF;
    else
      return s[7:0];
  endfunction

  // A start-of-frame byte is always an R byte, whatever the FSM thought.
  assign phase_eff = (bus.valid_i && bus.sof_i) ? PH_R : phase_q;

  always_comb begin
    phase_d   = phase_q;
    sum_vld_d = 1'b0;
    err_d     = bus.valid_i && bus.sof_i && (phase_q != PH_R);
    if (bus.valid_i) begin
      case (phase_eff)
        PH_R: phase_d = PH_G;
        PH_G: phase_d = PH_B;
        PH_B: begin
          phase_d   = PH_R;
          sum_vld_d = 1'b1;
        end
        default: phase_d = PH_R;
      endcase
    end
  end

  always_comb begin
    valid_d = sum_vld_q;
    y_d     = y_q;
    cb_d    = cb_q;
    cr_d    = cr_q;
    if (sum_vld_q) begin
      y_d  = sat8(sum_y);
      cb_d = sat8(sum_cb);
      cr_d = sat8(sum_cr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_R;
      sum_vld_q <= 1'b0;
      valid_q   <= 1'b0;
      y_q       <= '0;
      cb_q      <= '0;
      cr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      sum_vld_q <= sum_vld_d;
      valid_q   <= valid_d;
      y_q       <= y_d;
      cb_q      <= cb_d;
      cr_q      <= cr_d;
      err_q     <= err_d;
    end
  end

  rgb_to_ycbcr_mac #(
    .ACC_W(ACC_W), .COEF_R(Y_R), .COEF_G(Y_G), .COEF_B(Y_B), .BIAS(Y_BIAS)
  ) u_mac_y (
    .clk(clk), .rst(rst), .valid_i(bus.valid_i), .phase_i(phase_eff),
    .data_i(bus.rgb_data_i), .sum_o(sum_y)
  );

  rgb_to_ycbcr_mac #(
    .ACC_W(ACC_W), .COEF_R(CB_R), .COEF_G(CB_G), .COEF_B(CB_B), .BIAS(C_BIAS)
  ) u_mac_cb (
    .clk(clk), .rst(rst), .valid_i(bus.valid_i), .phase_i(phase_eff),
    .data_i(bus.rgb_data_i), .sum_o(sum_cb)
  );

  rgb_to_ycbcr_mac #(
    .ACC_W(ACC_W), .COEF_R(CR_R), .COEF_G(CR_G), .COEF_B(CR_B), .BIAS(C_BIAS)
  ) u_mac_cr (
    .clk(clk), .rst(rst), .valid_i(bus.valid_i), .phase_i(phase_eff),
    .data_i(bus.rgb_data_i), .sum_o(sum_cr)
  );

  assign bus.valid_o   = valid_q;
  assign bus.y_data_o  = y_q;
  assign bus.cb_data_o = cb_q;
  assign bus.cr_data_o = cr_q;
  assign bus.phase_o   = phase_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Testbench for rgb_to_ycbcr: scoreboard of expected pixels pushed when the
// B byte is driven, popped by a negedge monitor whenever valid_o pulses.
module tb_rgb_to_ycbcr;

  logic clk;
  logic rst;

  rgb_to_ycbcr_if ifc ();

  rgb_to_ycbcr dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } exp_t;

  exp_t sb[$];

  int checks     = 0;
  int errors     = 0;
  int err_cnt    = 0;
  int cyc        = 0;
  int last_vld   = -1;
  bit spacing_en = 1'b0;

  always @(posedge clk) cyc++;

  // Integer reference: floor((bias + sum) / 256) clamped to 0..255.
  function automatic logic [7:0] clamp_ref(input int v);
    int q;
    if (v < 0) return 8'd0;
    q = v / 256;
    if (q > 255) return 8'hFF;
    return 8'(q);
  endfunction

  function automatic exp_t model(input int r, input int g, input int b);
    exp_t e;
    e.y  = clamp_ref(128   +  77*r + 150*g +  29*b);
    e.cb = clamp_ref(32896 -  43*r -  85*g + 128*b);
    e.cr = clamp_ref(32896 + 128*r - 107*g -  21*b);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ifc.err_o) err_cnt++;
    if (ifc.valid_o) begin
      if (spacing_en && last_vld >= 0) begin
        checks++;
        if ((cyc - last_vld) !== 3) begin
          errors++;
          $display("FAIL valid_spacing: got %0d cycles, want 3", cyc - last_vld);
        end
      end
      last_vld = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: valid_o=1 with no pixel pending at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if ({ifc.y_data_o, ifc.cb_data_o, ifc.cr_data_o} !== {e.y, e.cb, e.cr}) begin
          errors++;
          $display("FAIL pixel_out: got Y=%0d Cb=%0d Cr=%0d, want Y=%0d Cb=%0d Cr=%0d",
                   ifc.y_data_o, ifc.cb_data_o, ifc.cr_data_o, e.y, e.cb, e.cr);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    ifc.valid_i    = v;
    ifc.sof_i      = s;
    ifc.rgb_data_i = d;
    @(posedge clk);
    #1;
    ifc.valid_i = 1'b0;
    ifc.sof_i   = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit push);
    drive(1'b1, 1'b0, r);
    drive(1'b1, 1'b0, g);
    if (push) sb.push_back(model(int'(r), int'(g), int'(b)));
    drive(1'b1, 1'b0, b);
  endtask

  task automatic drain(input string name);
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_output: %0d pixels pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.valid_i = 1'b0; ifc.sof_i = 1'b0; ifc.rgb_data_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifc.valid_o, ifc.err_o, ifc.phase_o, ifc.y_data_o, ifc.cb_data_o, ifc.cr_data_o} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b err=%b phase=%0d Y=%0d Cb=%0d Cr=%0d, want all 0",
               ifc.valid_o, ifc.err_o, ifc.phase_o, ifc.y_data_o, ifc.cb_data_o, ifc.cr_data_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_white_latency();
    drive(1'b1, 1'b1, 8'd255);
    drive(1'b1, 1'b0, 8'd255);
    sb.push_back(model(255, 255, 255));
    drive(1'b1, 1'b0, 8'd255);
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b0) begin
      errors++; $display("FAIL latency_early: valid_o=%b one cycle after B, want 0", ifc.valid_o);
    end
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b1) begin
      errors++; $display("FAIL latency_on: valid_o=%b two cycles after B, want 1", ifc.valid_o);
    end
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.y_data_o !== 8'd255) begin
      errors++; $display("FAIL pulse_hold: valid_o=%b Y=%0d, want 0 and held 255", ifc.valid_o, ifc.y_data_o);
    end
    drain("white");
  endtask

  task automatic test_basic_colours();
    send_pixel(8'd0, 8'd0, 8'd0, 1'b1);
    drain("black");
    send_pixel(8'd255, 8'd0, 8'd0, 1'b1);
    drain("red");
    send_pixel(8'd0, 8'd0, 8'd255, 1'b1);
    drain("blue");
  endtask

  task automatic test_gaps();
    drive(1'b1, 1'b0, 8'd255);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 8'hAA);
      checks++;
      if (ifc.phase_o !== 2'd1) begin
        errors++; $display("FAIL gap_phase_g: got %0d, want 1", ifc.phase_o);
      end
    end
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 8'h55);
      checks++;
      if (ifc.phase_o !== 2'd2) begin
        errors++; $display("FAIL gap_phase_b: got %0d, want 2", ifc.phase_o);
      end
    end
    sb.push_back(model(255, 0, 0));
    drive(1'b1, 1'b0, 8'd0);
    drain("gaps");
  endtask

  task automatic test_sof_error();
    int base;
    base = err_cnt;
    drive(1'b1, 1'b0, 8'd10);
    drive(1'b1, 1'b0, 8'd20);
    drive(1'b1, 1'b1, 8'd255);
    @(negedge clk);
    checks++;
    if (ifc.err_o !== 1'b1 || ifc.phase_o !== 2'd1) begin
      errors++; $display("FAIL sof_err_pulse: err=%b phase=%0d, want 1 and 1", ifc.err_o, ifc.phase_o);
    end
    drive(1'b1, 1'b0, 8'd255);
    @(negedge clk);
    checks++;
    if (ifc.err_o !== 1'b0) begin
      errors++; $display("FAIL sof_err_single: err=%b, want 0", ifc.err_o);
    end
    sb.push_back(model(255, 255, 255));
    drive(1'b1, 1'b0, 8'd255);
    drain("sof");
    checks++;
    if (err_cnt - base !== 1) begin
      errors++; $display("FAIL sof_err_count: got %0d pulses, want 1", err_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'd200);
    drive(1'b1, 1'b0, 8'd100);
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0;
    checks++;
    if (ifc.phase_o !== 2'd0) begin
      errors++; $display("FAIL rst_mid_phase: got %0d, want 0", ifc.phase_o);
    end
    @(posedge clk); #1;
    send_pixel(8'd0, 8'd0, 8'd255, 1'b1);
    drain("rst_mid");
    send_pixel(8'd255, 8'd255, 8'd255, 1'b0);
    rst = 1'b1; #2; rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.y_data_o !== 8'd0) begin
      errors++; $display("FAIL rst_inflight: valid=%b Y=%0d, want 0 and 0", ifc.valid_o, ifc.y_data_o);
    end
    @(posedge clk); #1;
    send_pixel(8'd255, 8'd0, 8'd0, 1'b1);
    drain("rst_after");
  endtask

  task automatic test_back_to_back();
    int n_before;
    n_before   = checks;
    last_vld   = -1;
    spacing_en = 1'b1;
    for (int i = 0; i < 40; i++)
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'b1);
    send_pixel(8'd0, 8'd255, 8'd0, 1'b1);
    send_pixel(8'd255, 8'd0, 8'd255, 1'b1);
    drain("stream");
    spacing_en = 1'b0;
    checks++;
    if (checks - n_before < 80) begin
      errors++; $display("FAIL stream_outputs: got %0d checks, want at least 80", checks - n_before - 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_white_latency();
    test_basic_colours();
    test_gaps();
    test_sof_error();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
